reg_write_scoreboard: RTL and testbench

Decode-stage hazard scoreboard for the 5-stage WISC-SP13 pipeline; writer-side counterpart to the read-count decoder. It decodes each issuing instruction's destination register, tracks in-flight writes through EX, MEM and WB, and stalls decode while a source register still has a pending write. The pipeline has no forwarding and no register-file bypass. It sits beside the decode stage and consumes the 2-bit read count (0/1/2) already produced for the same instruction.

---
 rtl/reg_write_scoreboard_pkg.sv | 89 ++++++++
 rtl/reg_write_scoreboard_dest_decode.sv | 43 ++++
 rtl/reg_write_scoreboard.sv | 74 +++++++
 tb/tb_reg_write_scoreboard.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_scoreboard_pkg.sv
// Shared WISC-SP13 ISA definitions for the decode-side hazard logic:
// opcodes, instruction field positions and the in-flight stage record.
package reg_write_scoreboard_pkg;

   localparam int INSTR_W  = 16;
   localparam int NUM_REGS = 8;
   localparam int REG_W    = 3;
   localparam int OP_W     = 5;

   // Instruction field positions
   localparam int OP_HI = 15;
   localparam int OP_LO = 11;
   localparam int RS_HI = 10;
   localparam int RS_LO = 8;
   localparam int RT_HI = 7;
   localparam int RT_LO = 5;
   localparam int RD_HI = 4;
   localparam int RD_LO = 2;

   localparam logic [REG_W-1:0] R7 = 3'd7;

   // Opcodes, shared with the read-count decoder
   localparam logic [OP_W-1:0] OP_HALT  = 5'b00000;
   localparam logic [OP_W-1:0] OP_NOP   = 5'b00001;
   localparam logic [OP_W-1:0] OP_J     = 5'b00100;
   localparam logic [OP_W-1:0] OP_JR    = 5'b00101;
   localparam logic [OP_W-1:0] OP_JAL   = 5'b00110;
   localparam logic [OP_W-1:0] OP_JALR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_ADDI  = 5'b01000;
   localparam logic [OP_W-1:0] OP_SUBI  = 5'b01001;
   localparam logic [OP_W-1:0] OP_XORI  = 5'b01010;
   localparam logic [OP_W-1:0] OP_ANDNI = 5'b01011;
   localparam logic [OP_W-1:0] OP_BEQZ  = 5'b01100;
   localparam logic [OP_W-1:0] OP_BNEZ  = 5'b01101;
   localparam logic [OP_W-1:0] OP_BLTZ  = 5'b01110;
   localparam logic [OP_W-1:0] OP_BGEZ  = 5'b01111;
   localparam logic [OP_W-1:0] OP_ST    = 5'b10000;
   localparam logic [OP_W-1:0] OP_LD    = 5'b10001;
   localparam logic [OP_W-1:0] OP_SLBI  = 5'b10010;
   localparam logic [OP_W-1:0] OP_STU   = 5'b10011;
   localparam logic [OP_W-1:0] OP_ROLI  = 5'b10100;
   localparam logic [OP_W-1:0] OP_SLLI  = 5'b10101;
   localparam logic [OP_W-1:0] OP_RORI  = 5'b10110;
   localparam logic [OP_W-1:0] OP_SRLI  = 5'b10111;
   localparam logic [OP_W-1:0] OP_LBI   = 5'b11000;
   localparam logic [OP_W-1:0] OP_BTR   = 5'b11001;
   localparam logic [OP_W-1:0] OP_SHIFT = 5'b11010;
   localparam logic [OP_W-1:0] OP_ARITH = 5'b11011;
   localparam logic [OP_W-1:0] OP_SEQ   = 5'b11100;
   localparam logic [OP_W-1:0] OP_SLT   = 5'b11101;
   localparam logic [OP_W-1:0] OP_SLE   = 5'b11110;
   localparam logic [OP_W-1:0] OP_SCO   = 5'b11111;

   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] rd;
   } stage_t;

   localparam stage_t STAGE_EMPTY = '{vld: 1'b0, rd: '0};

   function automatic logic [OP_W-1:0] get_op(input logic [INSTR_W-1:0] instr);
      return instr[OP_HI:OP_LO];
   endfunction

   function automatic logic [REG_W-1:0] get_rs(input logic [INSTR_W-1:0] instr);
      return instr[RS_HI:RS_LO];
   endfunction

   function automatic logic [REG_W-1:0] get_rt(input logic [INSTR_W-1:0] instr);
      return instr[RT_HI:RT_LO];
   endfunction

   function automatic logic [REG_W-1:0] get_rd(input logic [INSTR_W-1:0] instr);
      return instr[RD_HI:RD_LO];
   endfunction

   // One-hot register bit for a stage, zero when the stage holds a bubble
   function automatic logic [NUM_REGS-1:0] stage_mask(input stage_t s);
      logic [NUM_REGS-1:0] m;
      m = '0;
      if (s.vld) m[s.rd] = 1'b1;
      return m;
   endfunction

   function automatic logic stage_hit(input stage_t s, input logic [REG_W-1:0] r);
      return s.vld && (s.rd == r);
   endfunction

endpackage

// File: rtl/reg_write_scoreboard_dest_decode.sv
// Destination-register decode: which register, if any, an instruction writes.
module reg_write_scoreboard_dest_decode
   import reg_write_scoreboard_pkg::*;
(
   input  logic [INSTR_W-1:0] instr_i,
   output logic               writes_o,
   output logic [REG_W-1:0]   rd_o
);

   logic [OP_W-1:0] op;
   logic            unused_low_bits;

   assign op              = get_op(instr_i);
   assign unused_low_bits = ^instr_i[1:0];

   always_comb begin
      writes_o = 1'b0;
      rd_o     = '0;
      casez (op)
         OP_ARITH, OP_SHIFT, 5'b111??, OP_BTR: begin
            writes_o = 1'b1;
            rd_o     = get_rd(instr_i);
         end
         5'b010??, 5'b101??, OP_LD: begin
            writes_o = 1'b1;
            rd_o     = get_rt(instr_i);
         end
         OP_STU, OP_LBI, OP_SLBI: begin
            writes_o = 1'b1;
            rd_o     = get_rs(instr_i);
         end
         OP_JAL, OP_JALR: begin
            writes_o = 1'b1;
            rd_o     = R7;
         end
         default: begin
            writes_o = 1'b0;
            rd_o     = '0;
         end
      endcase
   end

endmodule

// File: rtl/reg_write_scoreboard.sv
// Decode-stage write scoreboard: tracks pending writes in EX/MEM/WB and
// stalls decode while a checked source register still has one in flight.
module reg_write_scoreboard
   import reg_write_scoreboard_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [INSTR_W-1:0]  id_instr,
   input  logic                id_valid,
   input  logic [1:0]          id_reg_reads,
   input  logic                flush,
   input  logic                freeze,
   output logic                stall,
   output logic [NUM_REGS-1:0] pend_mask
);

   stage_t ex_q, ex_d;
   stage_t mem_q, mem_d;
   stage_t wb_q, wb_d;

   logic             id_writes;
   logic [REG_W-1:0] id_rd;
   logic [REG_W-1:0] src_a, src_b;
   logic             check_a, check_b;
   logic             hit_a, hit_b;
   logic             hazard;
   logic             issue;

   reg_write_scoreboard_dest_decode u_dest_decode (
      .instr_i  (id_instr),
      .writes_o (id_writes),
      .rd_o     (id_rd)
   );

   assign src_a   = get_rs(id_instr);
   assign src_b   = get_rt(id_instr);
   // A read count of 3 behaves as 2
   assign check_a = (id_reg_reads != 2'd0);
   assign check_b = id_reg_reads[1];

   assign hit_a = check_a &
                  (stage_hit(ex_q, src_a) | stage_hit(mem_q, src_a) | stage_hit(wb_q, src_a));
   assign hit_b = check_b &
                  (stage_hit(ex_q, src_b) | stage_hit(mem_q, src_b) | stage_hit(wb_q, src_b));

   assign hazard    = id_valid & ~flush & (hit_a | hit_b);
   assign stall     = hazard;
   assign issue     = id_valid & ~flush & ~hazard & id_writes;
   assign pend_mask = stage_mask(ex_q) | stage_mask(mem_q) | stage_mask(wb_q);

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!freeze) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = issue ? '{vld: 1'b1, rd: id_rd} : STAGE_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= STAGE_EMPTY;
         mem_q <= STAGE_EMPTY;
         wb_q  <= STAGE_EMPTY;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench for reg_write_scoreboard with hand-computed expectations.
module tb_reg_write_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] id_instr = 16'h0000;
   logic        id_valid = 1'b0;
   logic [1:0]  id_reg_reads = 2'd0;
   logic        flush = 1'b0;
   logic        freeze = 1'b0;
   logic        stall;
   logic [7:0]  pend_mask;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   localparam logic [15:0] I_ADDI_R1  = 16'h4025;  // ADDI r1,r0,5
   localparam logic [15:0] I_ADD_R2   = 16'hD968;  // ADD r2,r1,r3
   localparam logic [15:0] I_LBI_R4   = 16'hC400;
   localparam logic [15:0] I_LBI_R5   = 16'hC500;
   localparam logic [15:0] I_LBI_R6   = 16'hC600;
   localparam logic [15:0] I_ADDI_R4  = 16'h4380;  // ADDI r4,r3,0
   localparam logic [15:0] I_ADDI_RDR4 = 16'h4480; // ADDI r4,r4,0
   localparam logic [15:0] I_JAL      = 16'h3000;
   localparam logic [15:0] I_JR_R7    = 16'h2F00;
   localparam logic [15:0] I_NOP      = 16'h0800;

   reg_write_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .id_instr     (id_instr),
      .id_valid     (id_valid),
      .id_reg_reads (id_reg_reads),
      .flush        (flush),
      .freeze       (freeze),
      .stall        (stall),
      .pend_mask    (pend_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then present this cycle's decode inputs and settle
   task automatic cycle(input logic [15:0] i, input logic v, input logic [1:0] r,
                        input logic fl = 1'b0, input logic fz = 1'b0);
      @(posedge clk);
      #1;
      id_instr     = i;
      id_valid     = v;
      id_reg_reads = r;
      flush        = fl;
      freeze       = fz;
      #1;
   endtask

   // Count stalled cycles starting with the current one, holding the reader
   task automatic count_stall(input logic [15:0] i, input logic [1:0] r, output int n);
      n = 0;
      while (stall === 1'b1 && n < 20) begin
         n++;
         cycle(i, 1'b1, r);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 4; k++) cycle(16'h0000, 1'b0, 2'd0);
   endtask

   task automatic gap(input int k, input int expn, input string tag);
      int n;
      cycle(I_ADDI_R1, 1'b1, 2'd1);
      for (int j = 0; j < k; j++) cycle(I_NOP, 1'b1, 2'd0);
      cycle(I_ADD_R2, 1'b1, 2'd2);
      count_stall(I_ADD_R2, 2'd2, n);
      chk(tag, n[7:0], expn[7:0]);
      drain();
   endtask

   initial begin
      int n, m;

      // Reset
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("reset_pend", pend_mask, 8'h00);
      chk("reset_stall", {7'b0, stall}, 8'h00);

      // Back-to-back dependent pair
      cycle(I_ADDI_R1, 1'b1, 2'd1);
      chk("hz_writer_stall", {7'b0, stall}, 8'h00);
      chk("hz_writer_pend", pend_mask, 8'h00);
      cycle(I_ADD_R2, 1'b1, 2'd2);
      chk("hz_c1_stall", {7'b0, stall}, 8'h01);
      chk("hz_c1_pend", pend_mask, 8'h02);
      cycle(I_ADD_R2, 1'b1, 2'd2);
      chk("hz_c2_stall", {7'b0, stall}, 8'h01);
      chk("hz_c2_pend", pend_mask, 8'h02);
      cycle(I_ADD_R2, 1'b1, 2'd2);
      chk("hz_c3_stall", {7'b0, stall}, 8'h01);
      chk("hz_c3_pend", pend_mask, 8'h02);
      cycle(I_ADD_R2, 1'b1, 2'd2);
      chk("hz_release_stall", {7'b0, stall}, 8'h00);
      chk("hz_release_pend", pend_mask, 8'h00);
      cycle(16'h0000, 1'b0, 2'd0);
      chk("hz_reader_in_ex", pend_mask, 8'h04);
      drain();
      chk("hz_drained", pend_mask, 8'h00);

      // Unrelated instructions between writer and reader
      gap(1, 2, "gap1_stalls");
      gap(2, 1, "gap2_stalls");
      gap(3, 0, "gap3_stalls");

      // Single-read masking of instr[7:5]
      cycle(I_LBI_R4, 1'b1, 2'd0);
      cycle(I_ADDI_R4, 1'b1, 2'd1);
      chk("mask_reads1_stall", {7'b0, stall}, 8'h00);
      chk("mask_pend", pend_mask, 8'h10);
      id_reg_reads = 2'd2;
      #1;
      chk("mask_reads2_stall", {7'b0, stall}, 8'h01);
      id_reg_reads = 2'd3;
      #1;
      chk("mask_reads3_stall", {7'b0, stall}, 8'h01);
      id_valid = 1'b0;
      #1;
      chk("mask_bubble_stall", {7'b0, stall}, 8'h00);
      drain();

      // Write-after-write never stalls
      cycle(I_ADDI_R1, 1'b1, 2'd1);
      cycle(I_ADDI_R1, 1'b1, 2'd1);
      chk("waw_stall", {7'b0, stall}, 8'h00);
      chk("waw_pend", pend_mask, 8'h02);
      drain();

      // Link register
      cycle(I_JAL, 1'b1, 2'd0);
      cycle(I_JR_R7, 1'b1, 2'd1);
      chk("jal_pend", pend_mask, 8'h80);
      count_stall(I_JR_R7, 2'd1, n);
      chk("jal_stalls", n[7:0], 8'd3);
      cycle(16'h0000, 1'b0, 2'd0);
      chk("jr_no_write", pend_mask, 8'h00);
      drain();

      // Flush on the second stall cycle
      cycle(I_ADDI_R1, 1'b1, 2'd1);
      cycle(I_ADD_R2, 1'b1, 2'd2);
      chk("fl_c1_stall", {7'b0, stall}, 8'h01);
      cycle(I_ADD_R2, 1'b1, 2'd2, 1'b1);
      chk("fl_c2_stall", {7'b0, stall}, 8'h00);
      chk("fl_c2_pend", pend_mask, 8'h02);
      cycle(16'h0000, 1'b0, 2'd0);
      chk("fl_wb_pend", pend_mask, 8'h02);
      cycle(16'h0000, 1'b0, 2'd0);
      chk("fl_clear_pend", pend_mask, 8'h00);
      cycle(16'h0000, 1'b0, 2'd0);
      chk("fl_bubble_pend", pend_mask, 8'h00);
      drain();

      // Freeze held 4 cycles during a hazard
      cycle(I_ADDI_R1, 1'b1, 2'd1);
      n = 0;
      for (int k = 0; k < 4; k++) begin
         cycle(I_ADD_R2, 1'b1, 2'd2, 1'b0, 1'b1);
         chk("fz_stall", {7'b0, stall}, 8'h01);
         chk("fz_pend", pend_mask, 8'h02);
         if (stall === 1'b1) n++;
      end
      cycle(I_ADD_R2, 1'b1, 2'd2);
      count_stall(I_ADD_R2, 2'd2, m);
      n = n + m;
      chk("fz_total_stalls", n[7:0], 8'd7);
      cycle(16'h0000, 1'b0, 2'd0);
      chk("fz_reader_in_ex", pend_mask, 8'h04);
      drain();

      // Reset with three writes in flight
      cycle(I_LBI_R4, 1'b1, 2'd0);
      cycle(I_LBI_R5, 1'b1, 2'd0);
      cycle(I_LBI_R6, 1'b1, 2'd0);
      cycle(I_ADDI_RDR4, 1'b1, 2'd1);
      chk("rst_pre_pend", pend_mask, 8'h70);
      chk("rst_pre_stall", {7'b0, stall}, 8'h01);
      rst = 1'b1;
      cycle(I_ADDI_RDR4, 1'b1, 2'd1);
      rst = 1'b0;
      chk("rst_post_pend", pend_mask, 8'h00);
      chk("rst_post_stall", {7'b0, stall}, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
